// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: state encoding, default
// parameters and datapath widths.
package alu_arb_pkg;

    localparam int              NUM_REQ_DEF = 4;
    localparam int              ALU_LAT_DEF = 1;
    localparam logic [3:0]      MAX_OP_DEF  = 4'd11;

    localparam int              DATA_W = 8;
    localparam int              OP_W   = 4;
    localparam int              RES_W  = 16;
    localparam int              CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request bit at or after ptr_i, wrapping around.
// Produces a one-hot grant and the matching index.
module rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N = NUM_REQ_DEF
) (
    input  logic [N-1:0]               req_i,
    input  logic [idx_width(N)-1:0]    ptr_i,
    output logic [N-1:0]               grant_o,
    output logic [idx_width(N)-1:0]    idx_o
);

    localparam int IDX_W = idx_width(N);

    logic             found_s;
    logic [IDX_W-1:0] cand_s;

    // Scan the requesters starting at the pointer and keep the first hit.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = IDX_W'((int'(ptr_i) + k) % N);
            if (!found_s && req_i[cand_s]) begin
                found_s         = 1'b1;
                grant_o[cand_s] = 1'b1;
                idx_o           = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU between NUM_REQ requesters: round-robin grant in
// IDLE, operand hold for ALU_LAT cycles, then a one-cycle response strobe.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int              NUM_REQ = NUM_REQ_DEF,
    parameter int              ALU_LAT = ALU_LAT_DEF,
    parameter logic [OP_W-1:0] MAX_OP  = MAX_OP_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]      req_a,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]      req_b,
    input  logic [NUM_REQ-1:0][OP_W-1:0]        req_op,
    input  logic [NUM_REQ-1:0]                  req_cin,
    output logic [DATA_W-1:0]                   alu_a,
    output logic [DATA_W-1:0]                   alu_b,
    output logic [OP_W-1:0]                     alu_op,
    output logic                                alu_cin,
    input  logic [RES_W-1:0]                    alu_result,
    input  logic                                alu_cout,
    input  logic                                alu_zflag,
    output logic                                resp_valid,
    output logic [idx_width(NUM_REQ)-1:0]       resp_id,
    output logic [RES_W-1:0]                    resp_result,
    output logic                                resp_cout,
    output logic                                resp_zflag,
    output logic                                resp_err,
    output logic                                busy
);

    localparam int              IDX_W    = idx_width(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);

    state_e              state_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W-1:0]    ptr_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    id_q;
    logic                busy_q;
    logic [DATA_W-1:0]   alu_a_q;
    logic [DATA_W-1:0]   alu_b_q;
    logic [OP_W-1:0]     alu_op_q;
    logic                alu_cin_q;
    logic                resp_valid_q;
    logic [IDX_W-1:0]    resp_id_q;
    logic [RES_W-1:0]    resp_result_q;
    logic                resp_cout_q;
    logic                resp_zflag_q;
    logic                resp_err_q;

    logic [NUM_REQ-1:0]  grant_s;
    logic [IDX_W-1:0]    gnt_idx_s;
    logic                take_s;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant_s),
        .idx_o   (gnt_idx_s)
    );

    // Grant is visible only in IDLE outside reset; pointer moves past the winner.
    always_comb begin
        req_ready = '0;
        take_s    = 1'b0;
        ptr_d     = '0;
        if (!rst && (state_q == ST_IDLE)) begin
            req_ready = grant_s;
            take_s    = |grant_s;
        end else begin
            req_ready = '0;
            take_s    = 1'b0;
        end
        if (gnt_idx_s == IDX_W'(NUM_REQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = gnt_idx_s + IDX_W'(1);
        end
    end

    // Control FSM with registered ALU drive and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            id_q          <= '0;
            busy_q        <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            alu_cin_q     <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_cout_q   <= 1'b0;
            resp_zflag_q  <= 1'b0;
            resp_err_q    <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (take_s) begin
                        alu_a_q   <= req_a[gnt_idx_s];
                        alu_b_q   <= req_b[gnt_idx_s];
                        alu_op_q  <= req_op[gnt_idx_s];
                        alu_cin_q <= req_cin[gnt_idx_s];
                        id_q      <= gnt_idx_s;
                        ptr_q     <= ptr_d;
                        busy_q    <= 1'b1;
                        // Illegal op bypasses the ALU and answers with an error.
                        if (req_op[gnt_idx_s] > MAX_OP) begin
                            state_q       <= ST_RESP;
                            resp_valid_q  <= 1'b1;
                            resp_id_q     <= gnt_idx_s;
                            resp_result_q <= '0;
                            resp_cout_q   <= 1'b0;
                            resp_zflag_q  <= 1'b0;
                            resp_err_q    <= 1'b1;
                        end else begin
                            state_q <= ST_EXEC;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == '0) begin
                        state_q       <= ST_RESP;
                        resp_valid_q  <= 1'b1;
                        resp_id_q     <= id_q;
                        resp_result_q <= alu_result;
                        resp_cout_q   <= alu_cout;
                        resp_zflag_q  <= alu_zflag;
                        resp_err_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign alu_cin     = alu_cin_q;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_cout   = resp_cout_q;
    assign resp_zflag  = resp_zflag_q;
    assign resp_err    = resp_err_q;
    assign busy        = busy_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the ALU.
REQ-002 Parameter ALU_LAT, default 1: cycles operands are held on the ALU before the result is sampled; legal range 1..8.
REQ-003 Parameter MAX_OP, default 4'd11: highest legal op_code.
REQ-004 One clock and one reset: reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  NUM_REQ  per-requester request valid.
REQ-008 req_ready  output  NUM_REQ  per-requester accept; at most one bit set per cycle.
REQ-009 req_a, req_b  input  NUM_REQ x 8  per-requester operands.
REQ-010 req_op  input  NUM_REQ x 4  per-requester op_code.
REQ-011 req_cin  input  NUM_REQ x 1  per-requester carry-in.
REQ-012 alu_a, alu_b  output  8  registered operands to the ALU.
REQ-013 alu_op  output  4  registered op_code to the ALU.
REQ-014 alu_cin  output  1  registered carry-in to the ALU.
REQ-015 alu_result  input  16  ALU result.
REQ-016 alu_cout, alu_zflag  input  1 each  ALU carry-out and zero flag.
REQ-017 resp_valid  output  1  one-cycle response strobe; no backpressure.
REQ-018 resp_id  output  log2(NUM_REQ)  index of the requester being answered.
REQ-019 resp_result  output  16;  resp_cout, resp_zflag, resp_err  output  1 each  captured response.
REQ-020 busy  output  1  high in any state other than IDLE.

Function
REQ-021 FSM states SHALL be IDLE, EXEC, RESP; encoding is not visible at the ports.
REQ-022 IDLE: when any req_valid bit is set, assert req_ready combinationally for exactly one requester, chosen round-robin starting at pointer ptr.
REQ-023 Transfer occurs on the rising edge where req_valid[i] and req_ready[i] are both high; in that cycle, latch operands, op_code, carry-in and requester index.
REQ-024 After a legal transfer (req_op <= MAX_OP), update ptr to (i+1) mod NUM_REQ, load cycle counter with ALU_LAT-1, and go to EXEC.
REQ-025 EXEC: hold alu_a/alu_b/alu_op/alu_cin stable; decrement the counter each cycle.
REQ-026 When the counter is 0 in EXEC, capture alu_result/alu_cout/alu_zflag into the resp_* registers and go to RESP.
REQ-027 RESP: resp_valid=1 for exactly one cycle with resp_id=i and resp_err=0; then return to IDLE.
REQ-028 Latency: resp_valid SHALL rise ALU_LAT+1 cycles after the transfer edge; minimum issue interval is ALU_LAT+2 cycles.
REQ-029 On an illegal op (req_op > MAX_OP), accept the request, update ptr, skip EXEC and go to RESP; respond with resp_err=1, resp_result=0, resp_cout=0, resp_zflag=0.
REQ-030 req_ready SHALL be all-zero in EXEC and RESP, and in IDLE when no req_valid bit is set.
REQ-031 A requester dropping req_valid before acceptance SHALL be legal; no state change.
REQ-032 Response fields SHALL hold their last value while resp_valid=0.

Reset
REQ-033 While rst=1: state=IDLE, ptr=0, counter=0, req_ready=0, resp_valid=0, busy=0, and all alu_* and resp_* outputs are 0.
REQ-034 Reset asserted in EXEC or RESP SHALL abort the operation with no resp_valid issued; the first grant after reset goes to the lowest-index valid requester.

Structure
REQ-035 Shared package alu_arb_pkg SHALL hold the state enum, the NUM_REQ/ALU_LAT/MAX_OP defaults, and the operand/op/result width constants.
REQ-036 Round-robin selection SHALL be the sub-module rr_arbiter; inputs are a request vector and ptr, outputs are a one-hot grant and an index.

Verification
REQ-037 Single request: req_valid[2]=1, A=8'h0F, B=8'h01, op=add, ALU_LAT=1 -> ready[2] at T; resp_valid at T+2 with resp_id=2 and resp_result=16'h0010.
REQ-038 All four valid continuously from reset -> grants in order 0,1,2,3,0; grants are spaced ALU_LAT+2 cycles apart.
REQ-039 Illegal op: req_op=4'hF on requester 1 -> accepted; resp_valid one cycle later with resp_err=1 and resp_result=0; ptr advances to 2.
REQ-040 Reset in EXEC with ALU_LAT=4 -> no resp_valid; outputs 0 on the next edge; the next grant goes to requester 0 when valid.
REQ-041 ALU_LAT=3, result forced to 16'h0000 with zflag=1 -> alu_* stable for 3 cycles; resp_zflag=1 at T+4.
